// File: rtl/excess3_serial_framer_if.sv
// Parallel digit handshake into the Excess-3 serial framer.
interface excess3_serial_framer_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/excess3_serial_framer.sv
// Serializes 4-bit Excess-3 digits LSB first for the serial Excess-3 to BCD converter.
// Each digit is framed as one converter-reset cycle followed by four data cycles,
// with a one-entry holding buffer so consecutive digits stream without gaps.
module excess3_serial_framer #(
  parameter bit CHECK_RANGE = 1'b1,
  parameter bit IDLE_X      = 1'b0
) (
  input  logic                          Clk,
  input  logic                          Rst,
  excess3_serial_framer_if.slave        bus,
  output logic                          X_out,
  output logic                          conv_rst,
  output logic                          bit_valid,
  output logic [1:0]                    bit_idx,
  output logic                          busy,
  output logic                          err_pulse
);

  typedef enum logic [2:0] {StIdle, StSync, StBit0, StBit1, StBit2, StBit3} state_e;

  state_e     state_q, state_d;
  logic [3:0] shift_q, shift_d;
  logic [3:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;

  logic       x_d, conv_rst_d, bit_valid_d, busy_d, err_d;
  logic [1:0] bit_idx_d;

  logic accept, bad_digit, load_ok;

  assign bus.in_ready = ~hold_full_q;
  assign accept       = bus.in_valid & bus.in_ready;
  assign bad_digit    = CHECK_RANGE && ((bus.in_data < 4'd3) || (bus.in_data > 4'd12));
  // Rejected digits still consume the handshake but never reach the shift or hold register.
  assign load_ok      = accept & ~bad_digit;

  // Next-state, shift-register and holding-buffer update.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      StIdle: begin
        if (load_ok) begin
          shift_d = bus.in_data;
          state_d = StSync;
        end
      end
      StSync: state_d = StBit0;
      StBit0: state_d = StBit1;
      StBit1: state_d = StBit2;
      StBit2: state_d = StBit3;
      StBit3: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = StSync;
        end else if (load_ok) begin
          shift_d = bus.in_data;
          state_d = StSync;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Mid-digit accepts park in the holding buffer (in_ready guarantees it is empty).
    if (load_ok && (state_q inside {StSync, StBit0, StBit1, StBit2})) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    x_d         = IDLE_X;
    conv_rst_d  = 1'b0;
    bit_valid_d = 1'b0;
    bit_idx_d   = 2'd0;
    busy_d      = (state_d != StIdle);
    err_d       = accept & bad_digit;
    case (state_d)
      StBit0: bit_idx_d = 2'd0;
      StBit1: bit_idx_d = 2'd1;
      StBit2: bit_idx_d = 2'd2;
      StBit3: bit_idx_d = 2'd3;
      default: bit_idx_d = 2'd0;
    endcase
    if (state_d inside {StBit0, StBit1, StBit2, StBit3}) begin
      x_d         = shift_d[bit_idx_d];
      conv_rst_d  = 1'b1;
      bit_valid_d = 1'b1;
    end
  end

  // State and output registers; reset also drops conv_rst, aborting the converter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StIdle;
      shift_q     <= 4'd0;
      hold_q      <= 4'd0;
      hold_full_q <= 1'b0;
      X_out       <= IDLE_X;
      conv_rst    <= 1'b0;
      bit_valid   <= 1'b0;
      bit_idx     <= 2'd0;
      busy        <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      X_out       <= x_d;
      conv_rst    <= conv_rst_d;
      bit_valid   <= bit_valid_d;
      bit_idx     <= bit_idx_d;
      busy        <= busy_d;
      err_pulse   <= err_d;
    end
  end

endmodule

// File: tb/tb_excess3_serial_framer.sv
// Directed bench for excess3_serial_framer: table of single digits plus stream,
// backpressure, mid-digit reset and unchecked-range sequences.
module tb_excess3_serial_framer;

  logic       clk;
  logic       rst;
  logic       x_out, conv_rst, bit_valid, busy, err_pulse;
  logic [1:0] bit_idx;
  logic       x_nc, conv_rst_nc, bit_valid_nc, busy_nc, err_nc;
  logic [1:0] bit_idx_nc;

  int n_vec = 0;
  int n_err = 0;

  excess3_serial_framer_if bus ();
  excess3_serial_framer_if bus_nc ();

  excess3_serial_framer #(.CHECK_RANGE(1'b1), .IDLE_X(1'b0)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .bus       (bus),
    .X_out     (x_out),
    .conv_rst  (conv_rst),
    .bit_valid (bit_valid),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  excess3_serial_framer #(.CHECK_RANGE(1'b0), .IDLE_X(1'b0)) dut_nc (
    .Clk       (clk),
    .Rst       (rst),
    .bus       (bus_nc),
    .X_out     (x_nc),
    .conv_rst  (conv_rst_nc),
    .bit_valid (bit_valid_nc),
    .bit_idx   (bit_idx_nc),
    .busy      (busy_nc),
    .err_pulse (err_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       exp_err;
    logic [3:0] exp_bits;
  } vec_t;

  vec_t vecs [8];

  logic [3:0] sdig     [16];
  int         acc_edge [16];
  logic [3:0] got      [$];
  int         busy_cnt;
  int         ready_low_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one digit from IDLE and follow it through SYNC, four bits and back to IDLE.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    chk("ready_before", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("err_pulse", err_pulse, v.exp_err);
    if (v.exp_err) begin
      chk("rej_busy", busy, 0);
      chk("rej_conv_rst", conv_rst, 0);
      chk("rej_bit_valid", bit_valid, 0);
      @(negedge clk);
      chk("rej_err_clear", err_pulse, 0);
      chk("rej_busy2", busy, 0);
      chk("rej_bit_valid2", bit_valid, 0);
    end else begin
      chk("sync_busy", busy, 1);
      chk("sync_conv_rst", conv_rst, 0);
      chk("sync_bit_valid", bit_valid, 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("bit_valid", bit_valid, 1);
        chk("bit_conv_rst", conv_rst, 1);
        chk("bit_idx", bit_idx, i);
        chk("x_out", x_out, v.exp_bits[i]);
      end
      @(negedge clk);
      chk("end_busy", busy, 0);
      chk("end_conv_rst", conv_rst, 0);
      chk("end_bit_valid", bit_valid, 0);
    end
  endtask

  // Hold in_valid high for n digits from sdig, collecting serialized digits.
  task automatic stream(input int n);
    int         k = 0;
    logic [3:0] cur = 4'd0;
    bit         acc;
    got.delete();
    busy_cnt      = 0;
    ready_low_cnt = 0;
    for (int c = 0; c < 12 * n + 10; c++) begin
      @(negedge clk);
      if (bit_valid) begin
        cur[bit_idx] = x_out;
        if (bit_idx == 2'd3) got.push_back(cur);
      end
      if (busy) busy_cnt++;
      if (!bus.in_ready) ready_low_cnt++;
      bus.in_valid = (k < n);
      bus.in_data  = (k < n) ? sdig[k] : 4'd0;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) begin
        acc_edge[k] = c;
        k++;
      end
    end
    bus.in_valid = 1'b0;
    chk("stream_accepts", k, n);
  endtask

  initial begin
    vecs[0] = '{4'd3,  1'b0, 4'b0011};
    vecs[1] = '{4'd12, 1'b0, 4'b1100};
    vecs[2] = '{4'd6,  1'b0, 4'b0110};
    vecs[3] = '{4'd9,  1'b0, 4'b1001};
    vecs[4] = '{4'd1,  1'b1, 4'b0000};
    vecs[5] = '{4'd13, 1'b1, 4'b0000};
    vecs[6] = '{4'd0,  1'b1, 4'b0000};
    vecs[7] = '{4'd15, 1'b1, 4'b0000};

    bus.in_valid    = 1'b0;
    bus.in_data     = 4'd0;
    bus_nc.in_valid = 1'b0;
    bus_nc.in_data  = 4'd0;
    rst = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_conv_rst", conv_rst, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_idx", bit_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_x_out", x_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Sweep 3..12 back to back.
    for (int i = 0; i < 10; i++) sdig[i] = 4'(i + 3);
    stream(10);
    chk("sweep_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      chk("sweep_bcd", 32'(got[i]) - 3, i);
    end
    chk("sweep_busy_cycles", busy_cnt, 50);
    chk("sweep_ready_low", ready_low_cnt, 36);
    chk("sweep_acc1", acc_edge[1] - acc_edge[0], 1);
    chk("sweep_acc9", acc_edge[9] - acc_edge[0], 41);

    // Backpressure 5, 7, 9: 9 waits until the hold drains at digit 5's BIT3 exit.
    sdig[0] = 4'd5;
    sdig[1] = 4'd7;
    sdig[2] = 4'd9;
    stream(3);
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_d0", got[0], 5);
      chk("bp_d1", got[1], 7);
      chk("bp_d2", got[2], 9);
    end
    chk("bp_acc7", acc_edge[1] - acc_edge[0], 1);
    chk("bp_acc9", acc_edge[2] - acc_edge[0], 6);
    chk("bp_ready_low", ready_low_cnt, 8);

    // Reset during BIT2 of digit 8 with 4 held behind it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd8;
    @(posedge clk);
    @(negedge clk);
    bus.in_data = 4'd4;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_hold_ready", bus.in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_bit_idx", bit_idx, 2);
    chk("mid_bit_valid", bit_valid, 1);
    rst = 1'b0;
    #1;
    chk("arst_conv_rst", conv_rst, 0);
    chk("arst_bit_valid", bit_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_bit_idx", bit_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
    end
    apply_vec('{4'd6, 1'b0, 4'b0110});

    // Unchecked range: 15 is serialized without error.
    @(negedge clk);
    bus_nc.in_valid = 1'b1;
    bus_nc.in_data  = 4'd15;
    @(posedge clk);
    @(negedge clk);
    bus_nc.in_valid = 1'b0;
    chk("nc_err", err_nc, 0);
    chk("nc_busy", busy_nc, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("nc_bit_valid", bit_valid_nc, 1);
      chk("nc_x_out", x_nc, 1);
      chk("nc_err_bit", err_nc, 0);
    end
    @(negedge clk);
    chk("nc_done", busy_nc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
